// File: rtl/req_burst_ctrl.sv
// req_burst_ctrl: turns per-client burst start pulses into held level requests with a release gap and wait timeout
module req_burst_ctrl #(
  parameter int LEN_W = 4,
  parameter int WAIT_MAX = 255,
  parameter int WCNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:1]       start,
  input  logic [LEN_W-1:0] len1,
  input  logic [LEN_W-1:0] len2,
  input  logic [LEN_W-1:0] len3,
  input  logic [3:1]       g,
  output logic [3:1]       r,
  output logic [3:1]       busy,
  output logic [3:1]       done,
  output logic [3:1]       timeout
);
  typedef enum logic [1:0] {IDLE, WAIT, XFER, GAP} state_t;
  for (genvar i = 1; i <= 3; i++) begin : ch
    state_t st;
    logic [LEN_W-1:0] len_i, len_q, beat_cnt;
    logic [WCNT_W-1:0] wait_cnt;
    logic r_q, busy_q, done_q, to_q;
    assign len_i = i == 1 ? len1 : i == 2 ? len2 : len3;
    assign r[i] = r_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;
    assign timeout[i] = to_q;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        len_q <= '0;
        beat_cnt <= '0;
        wait_cnt <= '0;
        r_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        to_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        to_q <= 1'b0;
        unique case (st)
          IDLE:
            if (start[i] && len_i != '0) begin
              st <= WAIT;
              len_q <= len_i;
              beat_cnt <= '0;
              wait_cnt <= '0;
              r_q <= 1'b1;
              busy_q <= 1'b1;
            end
          WAIT:
            if (g[i]) begin
              beat_cnt <= LEN_W'(1);
              if (len_q == LEN_W'(1)) begin
                st <= GAP;
                r_q <= 1'b0;
                done_q <= 1'b1;
              end else st <= XFER;
            end else if (wait_cnt == WCNT_W'(WAIT_MAX - 1)) begin
              st <= GAP;
              r_q <= 1'b0;
              to_q <= 1'b1;
            end else wait_cnt <= wait_cnt + WCNT_W'(1);
          XFER:
            if (g[i]) begin
              beat_cnt <= beat_cnt + LEN_W'(1);
              if (beat_cnt + LEN_W'(1) == len_q) begin
                st <= GAP;
                r_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          GAP: begin
            st <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
  end
endmodule

// File: tb/tb_req_burst_ctrl.sv
// tb_req_burst_ctrl: table-driven cycle vectors plus hand-written async reset sequence
module tb_req_burst_ctrl;
  localparam int LEN_W = 4, WAIT_MAX = 4, WCNT_W = 8;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:1] start = '0, g = '0, r, busy, done, timeout;
  logic [LEN_W-1:0] len1 = '0, len2 = '0, len3 = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:1] start;
    logic [LEN_W-1:0] l1, l2, l3;
    logic [3:1] g, r, busy, done, to;
  } vec_t;
  vec_t tbl[$];
  req_burst_ctrl #(.LEN_W(LEN_W), .WAIT_MAX(WAIT_MAX), .WCNT_W(WCNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2), .len3(len3),
    .g(g), .r(r), .busy(busy), .done(done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:1] act, input logic [3:1] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:1] er, eb, ed, et);
    chk({tag, " r"}, r, er);
    chk({tag, " busy"}, busy, eb);
    chk({tag, " done"}, done, ed);
    chk({tag, " timeout"}, timeout, et);
  endtask
  task automatic add(input logic [3:1] s, input int a, b, c, input logic [3:1] gg, er, eb, ed, et);
    vec_t v;
    v.start = s; v.l1 = LEN_W'(a); v.l2 = LEN_W'(b); v.l3 = LEN_W'(c);
    v.g = gg; v.r = er; v.busy = eb; v.done = ed; v.to = et;
    tbl.push_back(v);
  endtask
  initial begin
    // single burst, len 3, first grant one cycle after r rises
    add(3'b001, 3, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    // len 1 with immediate grant, then len 0 ignored
    add(3'b010, 0, 1, 0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b010, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // timeout on channel 3
    add(3'b100, 0, 0, 2, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b100, 3'b000, 3'b100);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // grant on the timeout edge wins and counts beat 1
    add(3'b001, 2, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // len 4 with grant dropped for 2 cycles mid-burst
    add(3'b001, 4, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    // three concurrent channels, rotating grants, extra start[1] during XFER
    add(3'b111, 2, 2, 2, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b111, 3'b000, 3'b000);
    add(3'b001, 3, 0, 0, 3'b010, 3'b111, 3'b111, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b100, 3'b111, 3'b111, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b111, 3'b001, 3'b000);
    add(3'b000, 0, 0, 0, 3'b010, 3'b100, 3'b110, 3'b010, 3'b000);
    add(3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b100, 3'b100, 3'b000);
    add(3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    add(3'b000, 0, 0, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk) reset = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].start; len1 = tbl[i].l1; len2 = tbl[i].l2; len3 = tbl[i].l3; g = tbl[i].g;
      @(posedge clk);
      #1 chk_all($sformatf("v%0d", i), tbl[i].r, tbl[i].busy, tbl[i].done, tbl[i].to);
    end
    // asynchronous reset in XFER
    @(negedge clk); start = 3'b010; len2 = 3; g = '0;
    @(negedge clk); start = '0; g = 3'b010;
    @(negedge clk);
    chk_all("pre_rst", 3'b010, 3'b010, 3'b000, 3'b000);
    #2 reset = 1'b1;
    #1 chk_all("async_rst", 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    chk_all("rst_hold", 3'b000, 3'b000, 3'b000, 3'b000);
    reset = 1'b0; g = '0; start = 3'b010; len2 = 1;
    @(posedge clk);
    #1 chk_all("post_rst_start", 3'b010, 3'b010, 3'b000, 3'b000);
    @(negedge clk); start = '0; g = 3'b010;
    @(posedge clk);
    #1 chk_all("post_rst_done", 3'b000, 3'b010, 3'b010, 3'b000);
    @(negedge clk); g = '0;
    @(posedge clk);
    #1 chk_all("post_rst_idle", 3'b000, 3'b000, 3'b000, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
